proj_fm_window_buf: RTL and testbench
=====================================

# proj_fm_window_buf

Multi-bank successor to the ping-pong genome frame memory: byte stream written into a ring of BANKS banks, each full bank read back as fixed-width windows of WIN_BYTES consecutive bytes at a configurable STRIDE. Adds valid/ready backpressure on both sides, partial-bank flush on `in_last`, and zero-padded tail windows. Sits between the genome byte source and the minhash k-mer hashing pipeline.

## Interface
- BANKS, 4: number of banks in the ring, ≥2.
- BANK_BYTES, 64: bytes per bank, power of 2, ≥ WIN_BYTES.
- DATA_BITS, 8: bits per genome byte.
- WIN_BYTES, 4: bytes per output window.
- STRIDE, 1: byte offset between consecutive windows, 1..BANK_BYTES.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  write byte valid.
- in_ready  out  1  write byte accepted when in_valid & in_ready.
- in_data  in  DATA_BITS  genome byte.
- in_last  in  1  final byte of sequence; closes current bank early.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- out_data  out  WIN_BYTES*DATA_BITS  window; byte i at bits [(i+1)*DATA_BITS-1 : i*DATA_BITS], byte 0 = lowest address.
- out_last  out  1  final window of an `in_last`-closed bank.

## Operation
- Bank state per bank: FREE → FILLING → FULL → READING → FREE. Write pointer `wb` and read pointer `rb` advance modulo BANKS.
- Write: `in_ready` = bank[wb] FREE or FILLING. On accept, byte stored at `waddr`, `waddr` increments. Bank closes (→FULL, fill = waddr+1, last flag = in_last) when waddr == BANK_BYTES-1 or in_last. On close `waddr`←0, `wb`←wb+1.
- Read FSM: IDLE (bank[rb] not FULL) → LOAD (issue read of WIN_BYTES bytes at `roff`) → PRESENT (out_valid=1, hold until out_ready) → LOAD or RELEASE.
- Window content: bytes at roff..roff+WIN_BYTES-1; any byte at address ≥ fill is 0.
- Windows emitted for roff = 0, STRIDE, 2·STRIDE, … while roff < fill−WIN_BYTES+1 for a full-length bank; for a last-flagged bank while roff < fill (tail padded). A last-flagged bank with fill < WIN_BYTES yields exactly one padded window.
- out_last = 1 only on the final window of a last-flagged bank.
- RELEASE: bank[rb] → FREE, rb←rb+1, roff←0, FSM → IDLE.
- roff width $clog2(BANK_BYTES)+1 to detect overrun without wrap.

## Timing
- Reset: in_ready=1 (all banks FREE), out_valid=0, out_last=0, out_data=0, wb=rb=0, waddr=roff=0, FSM IDLE.
- Write-to-read: bank closing at cycle t → FULL at t+1 → LOAD at t+1 → out_valid at t+2.
- Sustained throughput: one window per 2 cycles (LOAD/PRESENT); out_data, out_last stable while out_valid & ~out_ready.
- Release: bank FREE the cycle after its final window fires; in_ready may rise that same cycle.
- Simultaneous write-close and read-release of different banks both take effect in one cycle.
- All banks FULL/READING: in_ready=0; no byte dropped, no overwrite.
- rst_n low mid-operation: all contents discarded, state returns to reset values next edge; RAM contents not cleared.

## Structure
- proj_pkg gains: FM_BANK_COUNT, FM_BANK_BYTES, FM_WIN_BYTES, FM_STRIDE; typedef `fm_bank_state_e` {FREE, FILLING, FULL, READING}; typedef `fm_rd_state_e` {IDLE, LOAD, PRESENT, RELEASE}.
- Sub-module `proj_fm_bank`: one bank, single-byte write port, registered WIN_BYTES-wide read port with zero-padding against a fill input; instantiated BANKS times.

## Test plan
- BANKS=2, BANK_BYTES=16, WIN=4, STRIDE=4; write bytes 0x00..0x1F, out_ready=1 → 8 windows, first 0x03020100, fifth 0x13121110, out_last never set.
- STRIDE=1, write 16 bytes 0x00..0x0F → 13 windows, last 0x0F0E0D0C.
- WIN=4, STRIDE=4, write 6 bytes with in_last on 0x05 → windows 0x03020100 then 0x00000504 with out_last=1.
- Hold out_ready=0, stream 3 banks into BANKS=2 → in_ready falls after byte 32, no data loss; release out_ready → all windows in order.
- Single byte 0xAA with in_last → one window 0x000000AA, out_last=1, bank freed next cycle.
- Assert rst_n=0 mid-window with out_valid=1 → out_valid=0, in_ready=1 after next edge; fresh stream reads correctly from bank 0.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared constants and state encodings for the genome frame-memory window buffer.
package proj_pkg;
  localparam int FM_BANK_COUNT = 4;
  localparam int FM_BANK_BYTES = 64;
  localparam int FM_WIN_BYTES  = 4;
  localparam int FM_STRIDE     = 1;

  typedef enum logic [1:0] {FREE, FILLING, FULL, READING} fm_bank_state_e;
  typedef enum logic [1:0] {IDLE, LOAD, PRESENT, RELEASE} fm_rd_state_e;
endpackage

// File: rtl/proj_fm_bank.sv
// One frame-memory bank: byte write port, registered WIN_BYTES-wide read port,
// bytes at or beyond the fill level read back as zero.
module proj_fm_bank #(
  parameter int BANK_BYTES = 64,
  parameter int DATA_BITS  = 8,
  parameter int WIN_BYTES  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [$clog2(BANK_BYTES)-1:0]     waddr,
  input  logic [DATA_BITS-1:0]              wdata,
  input  logic                              re,
  input  logic [$clog2(BANK_BYTES):0]       raddr,
  input  logic [$clog2(BANK_BYTES):0]       fill,
  output logic [WIN_BYTES*DATA_BITS-1:0]    rdata
);
  localparam int AW = $clog2(BANK_BYTES);
  localparam int OW = AW + 1;

  logic [DATA_BITS-1:0] mem [BANK_BYTES];
  logic [WIN_BYTES-1:0][DATA_BITS-1:0] win;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // raddr has one spare bit so tail bytes past the bank end compare >= fill instead of wrapping
  for (genvar i = 0; i < WIN_BYTES; i++) begin : g_byte
    logic [OW-1:0] a;
    assign a      = raddr + OW'(i);
    assign win[i] = (a < fill) ? mem[a[AW-1:0]] : '0;
  end

  always_ff @(posedge clk)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= win;
endmodule

// File: rtl/proj_fm_window_buf.sv
// Ring of byte banks filled from the genome stream and read back as strided,
// zero-padded windows for the k-mer hashing pipeline.
module proj_fm_window_buf
  import proj_pkg::*;
#(
  parameter int BANKS      = FM_BANK_COUNT,
  parameter int BANK_BYTES = FM_BANK_BYTES,
  parameter int DATA_BITS  = 8,
  parameter int WIN_BYTES  = FM_WIN_BYTES,
  parameter int STRIDE     = FM_STRIDE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_BITS-1:0]           in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIN_BYTES*DATA_BITS-1:0] out_data,
  output logic                           out_last
);
  localparam int AW = $clog2(BANK_BYTES);
  localparam int OW = AW + 1;
  localparam int BW = $clog2(BANKS);
  localparam int DW = WIN_BYTES * DATA_BITS;
  localparam logic [AW-1:0] ALAST = AW'(BANK_BYTES - 1);
  localparam logic [OW-1:0] STEP  = OW'(STRIDE);
  localparam logic [OW-1:0] WINM1 = OW'(WIN_BYTES - 1);
  localparam logic [BW-1:0] BLAST = BW'(BANKS - 1);

  fm_bank_state_e bstate [BANKS];
  logic [OW-1:0]  fill   [BANKS];
  logic [BANKS-1:0] last_f;
  logic [BW-1:0]  wb, rb;
  logic [AW-1:0]  waddr;
  logic [OW-1:0]  roff, nxt_off, lim;
  fm_rd_state_e   rstate, rstate_nxt;
  logic [BANKS-1:0][DW-1:0] bank_rdata;
  logic wr_fire, wr_close, load, rd_fire, rd_done, final_w;

  assign in_ready = (bstate[wb] == FREE) || (bstate[wb] == FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign wr_close = wr_fire && ((waddr == ALAST) || in_last);
  assign out_data = bank_rdata[rb];

  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    proj_fm_bank #(
      .BANK_BYTES(BANK_BYTES), .DATA_BITS(DATA_BITS), .WIN_BYTES(WIN_BYTES)
    ) u_bank (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_fire && (wb == BW'(i))),
      .waddr(waddr),
      .wdata(in_data),
      .re   (load && (rb == BW'(i))),
      .raddr(roff),
      .fill (fill[i]),
      .rdata(bank_rdata[i])
    );
  end

  always_ff @(posedge clk)
    if (!rst_n) rstate <= IDLE;
    else        rstate <= rstate_nxt;

  // A full-length bank stops before the window would run off its end; a
  // last-flagged bank keeps going while the window start is in range.
  always_comb begin
    rstate_nxt = rstate;
    load       = 1'b0;
    rd_fire    = 1'b0;
    rd_done    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    lim        = last_f[rb] ? fill[rb] : fill[rb] - WINM1;
    nxt_off    = roff + STEP;
    final_w    = nxt_off >= lim;
    case (rstate)
      IDLE: if (bstate[rb] == FULL) begin
        load       = 1'b1;
        rstate_nxt = PRESENT;
      end
      LOAD: begin
        load       = 1'b1;
        rstate_nxt = PRESENT;
      end
      PRESENT: begin
        out_valid = 1'b1;
        out_last  = last_f[rb] && final_w;
        if (out_ready) begin
          rd_fire    = 1'b1;
          rd_done    = final_w;
          rstate_nxt = final_w ? IDLE : LOAD;
        end
      end
      default: rstate_nxt = IDLE;
    endcase
  end

  // Write side only touches FREE/FILLING banks, read side only FULL/READING,
  // so both updates can land in the same cycle without colliding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BANKS; i++) begin
        bstate[i] <= FREE;
        fill[i]   <= '0;
      end
      last_f <= '0;
      wb     <= '0;
      rb     <= '0;
      waddr  <= '0;
      roff   <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_close) begin
          bstate[wb] <= FULL;
          fill[wb]   <= OW'(waddr) + OW'(1);
          last_f[wb] <= in_last;
          waddr      <= '0;
          wb         <= (wb == BLAST) ? '0 : wb + BW'(1);
        end else begin
          bstate[wb] <= FILLING;
          waddr      <= waddr + AW'(1);
        end
      end
      if (load && rstate == IDLE) bstate[rb] <= READING;
      if (rd_fire) roff <= rd_done ? '0 : nxt_off;
      if (rd_done) begin
        bstate[rb] <= FREE;
        rb         <= (rb == BLAST) ? '0 : rb + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_proj_fm_window_buf.sv
// Directed bench: two instances (STRIDE=4 and STRIDE=1), 2 banks of 16 bytes, 4-byte windows.
module tb_proj_fm_window_buf;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_data;
  logic [31:0] a_out_data;
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_data;
  logic [31:0] b_out_data;

  proj_fm_window_buf #(.BANKS(2), .BANK_BYTES(16), .DATA_BITS(8), .WIN_BYTES(4), .STRIDE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last));

  proj_fm_window_buf #(.BANKS(2), .BANK_BYTES(16), .DATA_BITS(8), .WIN_BYTES(4), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last));

  // Windows that fire at the coming edge, captured mid-cycle
  logic [31:0] qa_d[$];
  logic        qa_l[$];
  logic [31:0] qb_d[$];
  logic        qb_l[$];
  int          qb_c[$];
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      qa_d.push_back(a_out_data);
      qa_l.push_back(a_out_last);
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      qb_d.push_back(b_out_data);
      qb_l.push_back(b_out_last);
      qb_c.push_back(cyc);
    end
  end

  function automatic logic [31:0] win4(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic push_a(input logic [7:0] d, input logic l);
    int n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!a_in_ready) begin errors++; $display("FAIL push_a timeout byte=%h in_ready=%b want 1", d, a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d, input logic l);
    int n = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
    @(negedge clk);
    while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!b_in_ready) begin errors++; $display("FAIL push_b timeout byte=%h in_ready=%b want 1", d, b_in_ready); end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  // Wait for n windows, then idle a few cycles so extra windows would show up in the count
  task automatic wait_a(input int n);
    int k = 0;
    while (qa_d.size() < n && k < 500) begin @(posedge clk); #1; k++; end
    repeat (8) @(posedge clk); #1;
    checks++;
    if (qa_d.size() != n) begin errors++; $display("FAIL a_window_count got=%0d want=%0d", qa_d.size(), n); end
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (qb_d.size() < n && k < 500) begin @(posedge clk); #1; k++; end
    repeat (8) @(posedge clk); #1;
    checks++;
    if (qb_d.size() != n) begin errors++; $display("FAIL b_window_count got=%0d want=%0d", qb_d.size(), n); end
  endtask

  task automatic test_reset();
    checks += 4;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
    if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", a_out_last); end
    if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", a_out_data); end
  endtask

  task automatic test_stride4();
    qa_d.delete(); qa_l.delete();
    a_out_ready = 1'b1;
    for (int i = 0; i < 32; i++) push_a(8'(i), 1'b0);
    wait_a(8);
    for (int k = 0; k < 8 && k < qa_d.size(); k++) begin
      checks += 2;
      if (qa_d[k] !== win4(4 * k)) begin errors++; $display("FAIL stride4_data[%0d] got=%h want=%h", k, qa_d[k], win4(4 * k)); end
      if (qa_l[k] !== 1'b0) begin errors++; $display("FAIL stride4_last[%0d] got=%b want=0", k, qa_l[k]); end
    end
    checks++;
    if (qa_d.size() > 4 && qa_d[4] !== 32'h13121110) begin errors++; $display("FAIL stride4_fifth got=%h want=13121110", qa_d[4]); end
  endtask

  task automatic test_stride1_back_to_back();
    qb_d.delete(); qb_l.delete(); qb_c.delete();
    for (int i = 0; i < 16; i++) push_b(8'(i), 1'b0);
    wait_b(13);
    for (int k = 0; k < 13 && k < qb_d.size(); k++) begin
      checks += 2;
      if (qb_d[k] !== win4(k)) begin errors++; $display("FAIL stride1_data[%0d] got=%h want=%h", k, qb_d[k], win4(k)); end
      if (qb_l[k] !== 1'b0) begin errors++; $display("FAIL stride1_last[%0d] got=%b want=0", k, qb_l[k]); end
      if (k > 0) begin
        checks++;
        if (qb_c[k] - qb_c[k - 1] != 2) begin errors++; $display("FAIL stride1_rate[%0d] gap=%0d want=2", k, qb_c[k] - qb_c[k - 1]); end
      end
    end
    checks++;
    if (qb_d.size() == 13 && qb_d[12] !== 32'h0F0E0D0C) begin errors++; $display("FAIL stride1_final got=%h want=0f0e0d0c", qb_d[12]); end
  endtask

  task automatic test_last_tail();
    qa_d.delete(); qa_l.delete();
    for (int i = 0; i < 6; i++) push_a(8'(i), i == 5);
    wait_a(2);
    if (qa_d.size() == 2) begin
      checks += 4;
      if (qa_d[0] !== 32'h03020100) begin errors++; $display("FAIL tail_w0 got=%h want=03020100", qa_d[0]); end
      if (qa_l[0] !== 1'b0) begin errors++; $display("FAIL tail_l0 got=%b want=0", qa_l[0]); end
      if (qa_d[1] !== 32'h00000504) begin errors++; $display("FAIL tail_w1 got=%h want=00000504", qa_d[1]); end
      if (qa_l[1] !== 1'b1) begin errors++; $display("FAIL tail_l1 got=%b want=1", qa_l[1]); end
    end
  endtask

  task automatic test_single_byte();
    qa_d.delete(); qa_l.delete();
    a_out_ready = 1'b0;
    push_a(8'hAA, 1'b1);
    checks++;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b want=0", a_out_valid); end
    @(posedge clk); #1;
    checks += 3;
    if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", a_out_valid); end
    if (a_out_data !== 32'h000000AA) begin errors++; $display("FAIL single_data got=%h want=000000aa", a_out_data); end
    if (a_out_last !== 1'b1) begin errors++; $display("FAIL single_last got=%b want=1", a_out_last); end
    push_a(8'hBB, 1'b1);
    checks++;
    if (a_in_ready !== 1'b0) begin errors++; $display("FAIL single_full_in_ready got=%b want=0", a_in_ready); end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_freed_in_ready got=%b want=1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_gap_valid got=%b want=0", a_out_valid); end
    @(posedge clk); #1;
    checks += 3;
    if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single2_valid got=%b want=1", a_out_valid); end
    if (a_out_data !== 32'h000000BB) begin errors++; $display("FAIL single2_data got=%h want=000000bb", a_out_data); end
    if (a_out_last !== 1'b1) begin errors++; $display("FAIL single2_last got=%b want=1", a_out_last); end
    wait_a(2);
  endtask

  task automatic test_backpressure();
    qa_d.delete(); qa_l.delete();
    a_out_ready = 1'b0;
    for (int i = 0; i < 32; i++) push_a(8'(i), 1'b0);
    checks++;
    if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", a_in_ready); end
    fork
      for (int i = 32; i < 48; i++) push_a(8'(i), 1'b0);
      begin
        repeat (10) @(posedge clk); #1;
        checks += 4;
        if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got=%b want=0", a_in_ready); end
        if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%b want=1", a_out_valid); end
        if (a_out_data !== 32'h03020100) begin errors++; $display("FAIL bp_hold_data got=%h want=03020100", a_out_data); end
        if (qa_d.size() != 0) begin errors++; $display("FAIL bp_no_fire got=%0d want=0", qa_d.size()); end
        a_out_ready = 1'b1;
      end
    join
    wait_a(12);
    for (int k = 0; k < 12 && k < qa_d.size(); k++) begin
      checks++;
      if (qa_d[k] !== win4(4 * k)) begin errors++; $display("FAIL bp_data[%0d] got=%h want=%h", k, qa_d[k], win4(4 * k)); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h10 + i), i == 3);
    while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b want=1", a_out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks += 4;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", a_out_valid); end
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", a_in_ready); end
    if (a_out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h want=0", a_out_data); end
    if (a_out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last got=%b want=0", a_out_last); end
    rst_n = 1'b1;
    qa_d.delete(); qa_l.delete();
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_a(8'(8'h40 + i), 1'b0);
    wait_a(4);
    for (int k = 0; k < 4 && k < qa_d.size(); k++) begin
      checks++;
      if (qa_d[k] !== win4(8'h40 + 4 * k)) begin errors++; $display("FAIL rstmid_fresh[%0d] got=%h want=%h", k, qa_d[k], win4(8'h40 + 4 * k)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_stride4();
    test_stride1_back_to_back();
    test_last_tail();
    test_single_byte();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
